// File: rtl/perspective_correct_pkg.sv
// Shared Q16.16 types, constants and the saturating multiply used by the
// perspective-correction stage and its neighbours.
package perspective_correct_pkg;

  typedef logic signed [31:0] fp32_t;

  typedef struct packed {
    fp32_t x;
    fp32_t y;
    fp32_t z;
    fp32_t u;
    fp32_t v;
    fp32_t r;
    fp32_t g;
    fp32_t b;
    fp32_t a;
    logic  valid;
  } fragment_t;

  localparam fp32_t FP_ONE = 32'sh0001_0000;
  localparam fp32_t FP_MAX = 32'sh7FFF_FFFF;
  localparam fp32_t FP_MIN = 32'sh8000_0000;

  // u, v, r, g, b, a
  localparam int NUM_LANES = 6;

  typedef enum logic [1:0] {IDLE, DIVIDE, MULTIPLY, OUTPUT} state_t;

  // Q16.16 multiply, floor rounding, clamped to the representable range.
  // The result fits iff the top 17 product bits are a pure sign extension.
  function automatic fp32_t fp_mul_sat(fp32_t a, fp32_t b);
    logic signed [63:0] ae, be, p;
    fp32_t res;
    ae = a;
    be = b;
    p  = ae * be;
    if (&p[63:47] || ~|p[63:47]) res = fp32_t'(p[47:16]);
    else                         res = p[63] ? FP_MIN : FP_MAX;
    return res;
  endfunction

endpackage

// File: rtl/perspective_correct_if.sv
// Rasterizer-side and pixel-ops-side handshakes of the perspective stage.
interface perspective_correct_if;
  import perspective_correct_pkg::*;

  fragment_t frag_in;
  fp32_t     w_in;
  logic      in_valid;
  logic      in_ready;
  fragment_t frag_out;
  logic      out_valid;
  logic      out_ready;
  logic      busy;
  logic      w_err;

  modport slave (
    input  frag_in, w_in, in_valid, out_ready,
    output in_ready, frag_out, out_valid, busy, w_err
  );

  modport master (
    output frag_in, w_in, in_valid, out_ready,
    input  in_ready, frag_out, out_valid, busy, w_err
  );
endinterface

// File: rtl/perspective_correct_recip.sv
// Iterative reciprocal: restoring division of 2^32 by divisor, K_BITS
// quotient bits per cycle, MSB first. done is high during the last
// iteration cycle; quotient is valid while done is high.
module fp_recip_iter #(
  parameter int K_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);
  localparam int         ITERS = 32 / K_BITS;
  localparam logic [5:0] LAST  = 6'(ITERS - 1);

  logic        act;
  logic [5:0]  cnt;
  logic [32:0] rem, rem_nxt;
  logic [31:0] quo, quo_nxt, dvs;

  assign done     = act && (cnt == LAST);
  assign quotient = quo_nxt;

  // K_BITS restoring steps; remainder stays below divisor < 2^31
  always_comb begin
    rem_nxt = rem;
    quo_nxt = quo;
    for (int i = 0; i < K_BITS; i++) begin
      rem_nxt = {rem_nxt[31:0], 1'b0};
      quo_nxt = {quo_nxt[30:0], 1'b0};
      if (rem_nxt >= {1'b0, dvs}) begin
        rem_nxt    = rem_nxt - {1'b0, dvs};
        quo_nxt[0] = 1'b1;
      end
    end
  end

  // Remainder starts at 1: the dividend's bit 32, whose quotient bit is 0
  // because the divisor is always >= 2 here.
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (start) begin
      act <= 1'b1;
      cnt <= '0;
      rem <= 33'd1;
      quo <= '0;
      dvs <= divisor;
    end else if (act) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 6'd1;
      if (done) act <= 1'b0;
    end
  end
endmodule

// File: rtl/perspective_correct.sv
// Perspective correction: divides u, v, r, g, b, a by w using one
// iterative reciprocal per fragment and six parallel saturating multiplies.
module perspective_correct
  import perspective_correct_pkg::*;
#(
  parameter int K_BITS = 1
) (
  input logic clk,
  input logic rst,
  perspective_correct_if.slave bus
);
  state_t    state;
  fragment_t frag_q, mul_frag;
  fp32_t     recip;
  logic      accept, w_small, div_done;
  logic [31:0] div_q;
  fp32_t [NUM_LANES-1:0] lane_in, lane_out;

  assign w_small  = bus.w_in < 32'sd2;
  assign accept   = (state == IDLE) && bus.in_ready && bus.in_valid;
  assign bus.busy = (state != IDLE);

  fp_recip_iter #(.K_BITS(K_BITS)) u_recip (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && !w_small),
    .divisor  (bus.w_in),
    .done     (div_done),
    .quotient (div_q)
  );

  assign lane_in = {frag_q.a, frag_q.b, frag_q.g, frag_q.r, frag_q.v, frag_q.u};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_out[l] = fp_mul_sat(lane_in[l], recip);
  end

  // Corrected fragment: position passes through, attributes scaled by 1/w
  always_comb begin
    mul_frag       = frag_q;
    mul_frag.u     = lane_out[0];
    mul_frag.v     = lane_out[1];
    mul_frag.r     = lane_out[2];
    mul_frag.g     = lane_out[3];
    mul_frag.b     = lane_out[4];
    mul_frag.a     = lane_out[5];
    mul_frag.valid = 1'b1;
  end

  // Control FSM; every handshake output is a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      frag_q        <= '0;
      recip         <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.frag_out  <= '0;
      bus.w_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            frag_q       <= bus.frag_in;
            bus.in_ready <= 1'b0;
            if (w_small) begin
              bus.w_err <= 1'b1;
              recip     <= FP_MAX;
              state     <= MULTIPLY;
            end else begin
              state     <= DIVIDE;
            end
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            recip <= div_q[31] ? FP_MAX : fp32_t'(div_q);
            state <= MULTIPLY;
          end
        end
        MULTIPLY: begin
          bus.frag_out  <= mul_frag;
          bus.out_valid <= 1'b1;
          state         <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
